// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one command byte from the host to a PS/2 device over open-drain clock/data enables.
// Build option: define PS2_TX_FILTER_EN to insert an 8-sample glitch filter on the synchronised PS/2 clock.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES       = 5000,
  parameter int unsigned START_TIMEOUT_CYCLES = 750000,
  parameter int unsigned XFER_TIMEOUT_CYCLES  = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic [1:0] err_code
);

  localparam int unsigned MAX_AB = (INHIBIT_CYCLES > START_TIMEOUT_CYCLES) ? INHIBIT_CYCLES : START_TIMEOUT_CYCLES;
  localparam int unsigned MAX_C  = (MAX_AB > XFER_TIMEOUT_CYCLES) ? MAX_AB : XFER_TIMEOUT_CYCLES;
  localparam int unsigned CW     = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] INH_LAST   = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] START_LAST = CW'(START_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] XFER_LAST  = CW'(XFER_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX    = '1;

  localparam logic [1:0] ERR_START = 2'b01;
  localparam logic [1:0] ERR_XFER  = 2'b10;
  localparam logic [1:0] ERR_NACK  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_WAIT_START,
    S_SEND,
    S_STOP,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  logic r_clk_s1, r_clk_s2, r_data_s1, r_data_s2, r_clk_prev;
  logic w_sync_clk, w_fall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clk_s1  <= '1;
      r_clk_s2  <= '1;
      r_data_s1 <= '1;
      r_data_s2 <= '1;
    end else begin
      r_clk_s1  <= ps2_clk_in;
      r_clk_s2  <= r_clk_s1;
      r_data_s1 <= ps2_data_in;
      r_data_s2 <= r_data_s1;
    end
  end

`ifdef PS2_TX_FILTER_EN
  logic       r_clk_filt;
  logic [2:0] r_filt_cnt;

  // Filtered clock flips only on the 8th consecutive sample that disagrees with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clk_filt <= '1;
      r_filt_cnt <= '0;
    end else if (r_clk_s2 == r_clk_filt) begin
      r_filt_cnt <= '0;
    end else if (r_filt_cnt == 3'd7) begin
      r_clk_filt <= r_clk_s2;
      r_filt_cnt <= '0;
    end else begin
      r_filt_cnt <= r_filt_cnt + 3'd1;
    end
  end

  assign w_sync_clk = r_clk_filt;
`else
  assign w_sync_clk = r_clk_s2;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_clk_prev <= '1;
    else        r_clk_prev <= w_sync_clk;
  end

  assign w_fall = r_clk_prev & ~w_sync_clk;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [7:0]    r_byte, w_byte_nxt;
  logic          r_parity, w_parity_nxt;
  logic [3:0]    r_bit_idx, w_bit_nxt;
  logic          r_clk_oe, w_clk_oe_nxt;
  logic          r_data_oe, w_data_oe_nxt;
  logic          r_done, w_done_nxt;
  logic          r_error, w_error_nxt;
  logic [1:0]    r_err_code, w_err_code_nxt;
  logic          w_abort;
  logic [1:0]    w_abort_code;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_byte     <= '0;
      r_parity   <= '0;
      r_bit_idx  <= '0;
      r_clk_oe   <= '0;
      r_data_oe  <= '0;
      r_done     <= '0;
      r_error    <= '0;
      r_err_code <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_byte     <= w_byte_nxt;
      r_parity   <= w_parity_nxt;
      r_bit_idx  <= w_bit_nxt;
      r_clk_oe   <= w_clk_oe_nxt;
      r_data_oe  <= w_data_oe_nxt;
      r_done     <= w_done_nxt;
      r_error    <= w_error_nxt;
      r_err_code <= w_err_code_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1);
    w_byte_nxt     = r_byte;
    w_parity_nxt   = r_parity;
    w_bit_nxt      = r_bit_idx;
    w_clk_oe_nxt   = r_clk_oe;
    w_data_oe_nxt  = r_data_oe;
    w_done_nxt     = 1'b0;
    w_error_nxt    = 1'b0;
    w_err_code_nxt = r_err_code;
    w_abort        = 1'b0;
    w_abort_code   = '0;

    unique case (r_state)
      S_IDLE: begin
        w_cnt_nxt     = '0;
        w_clk_oe_nxt  = 1'b0;
        w_data_oe_nxt = 1'b0;
        if (tx_valid) begin
          w_state_nxt  = S_INHIBIT;
          w_byte_nxt   = tx_data;
          w_parity_nxt = ~^tx_data;
          w_clk_oe_nxt = 1'b1;
        end
      end
      S_INHIBIT: begin
        if (r_cnt >= INH_LAST) begin
          w_state_nxt   = S_RTS;
          w_data_oe_nxt = 1'b1;
          w_cnt_nxt     = '0;
        end
      end
      S_RTS: begin
        w_state_nxt  = S_WAIT_START;
        w_clk_oe_nxt = 1'b0;
        w_cnt_nxt    = '0;
      end
      S_WAIT_START: begin
        // The counter is reused from here on as the whole-transfer timeout.
        if (w_fall) begin
          w_state_nxt   = S_SEND;
          w_data_oe_nxt = ~r_byte[0];
          w_bit_nxt     = 4'd1;
          w_cnt_nxt     = '0;
        end else if (r_cnt >= START_LAST) begin
          w_abort      = 1'b1;
          w_abort_code = ERR_START;
        end
      end
      S_SEND: begin
        if (r_cnt >= XFER_LAST) begin
          w_abort      = 1'b1;
          w_abort_code = ERR_XFER;
        end else if (w_fall) begin
          if (r_bit_idx == 4'd8) begin
            w_data_oe_nxt = ~r_parity;
            w_state_nxt   = S_STOP;
          end else begin
            w_data_oe_nxt = ~r_byte[r_bit_idx[2:0]];
            w_bit_nxt     = r_bit_idx + 4'd1;
          end
        end
      end
      S_STOP: begin
        if (r_cnt >= XFER_LAST) begin
          w_abort      = 1'b1;
          w_abort_code = ERR_XFER;
        end else if (w_fall) begin
          w_data_oe_nxt = 1'b0;
          w_state_nxt   = S_ACK;
        end
      end
      S_ACK: begin
        if (r_cnt >= XFER_LAST) begin
          w_abort      = 1'b1;
          w_abort_code = ERR_XFER;
        end else if (w_fall) begin
          if (r_data_s2) begin
            w_abort      = 1'b1;
            w_abort_code = ERR_NACK;
          end else begin
            w_state_nxt = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (r_cnt >= XFER_LAST) begin
          w_abort      = 1'b1;
          w_abort_code = ERR_XFER;
        end else if (w_sync_clk && r_data_s2) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_clk_oe_nxt  = 1'b0;
        w_data_oe_nxt = 1'b0;
      end
    endcase

    if (w_abort) begin
      w_state_nxt    = S_IDLE;
      w_clk_oe_nxt   = 1'b0;
      w_data_oe_nxt  = 1'b0;
      w_error_nxt    = 1'b1;
      w_err_code_nxt = w_abort_code;
    end
  end

  assign tx_ready    = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;
  assign tx_done     = r_done;
  assign tx_error    = r_error;
  assign err_code    = r_err_code;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized scoreboard bench with a PS/2 device model on a wired-AND bus.
module tb_ps2_host_tx;

  localparam int unsigned INH = 10;
  localparam int unsigned STO = 200;
  localparam int unsigned XTO = 2000;

  localparam int M_ACK   = 0;
  localparam int M_NOACK = 1;
  localparam int M_NOCLK = 2;
  localparam int M_STOP4 = 3;
  localparam int M_RESET = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       busy, tx_done, tx_error;
  logic [1:0] err_code;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;

  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .START_TIMEOUT_CYCLES(STO),
    .XFER_TIMEOUT_CYCLES(XTO)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .ps2_clk_in(ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy(busy),
    .tx_done(tx_done),
    .tx_error(tx_error),
    .err_code(err_code)
  );

  typedef struct {
    bit          is_err;
    int          code;
    logic [10:0] frame;
    int          nbits;
    int          mode;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_err = 0;
  logic [10:0] dev_frame = '0;
  int          dev_n = 0;
  int          cyc = 0;
  int          rel_cyc = 0;
  int          inh_run = 0;
  int          rts_run = 0;
  logic        prev_clk_oe = 1'b0;
  int          last_code = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: bus-phase timing plus scoreboard pop on every done/error pulse.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      inh_run     = 0;
      rts_run     = 0;
      prev_clk_oe = 1'b0;
    end else begin
      if (ps2_clk_oe && !ps2_data_oe) inh_run++;
      if (ps2_clk_oe && ps2_data_oe)  rts_run++;
      if (prev_clk_oe && !ps2_clk_oe) begin
        chk("inhibit_len", inh_run, INH);
        chk("rts_len", rts_run, 1);
        inh_run = 0;
        rts_run = 0;
        rel_cyc = cyc;
      end
      prev_clk_oe = ps2_clk_oe;
      if (tx_done || tx_error) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {tx_done, tx_error}, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("tx_done", tx_done, !mon_e.is_err);
          chk("tx_error", tx_error, mon_e.is_err);
          if (mon_e.is_err) chk("err_code", err_code, mon_e.code);
          if (mon_e.mode == M_NOCLK) chk("start_timeout_cycles", cyc - rel_cyc, STO);
          chk("oe_released", {ps2_clk_oe, ps2_data_oe}, 0);
          chk("ready_at_pulse", tx_ready, 1);
          chk("frame_len", dev_n, mon_e.nbits);
          for (int i = 0; i < mon_e.nbits && i < 11; i++)
            chk($sformatf("frame_bit%0d", i), dev_frame[i], mon_e.frame[i]);
        end
      end
    end
  end

  task automatic device(input int mode);
    int k;
    dev_n = 0;
    k = 0;
    while (!(!ps2_clk_oe && ps2_data_oe) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("rts_seen", (!ps2_clk_oe && ps2_data_oe), 1);
    if (mode == M_NOCLK) return;
`ifdef PS2_TX_FILTER_EN
    repeat (5) @(negedge clk);
    dev_clk = 1'b0;
    repeat (3) @(negedge clk);
    dev_clk = 1'b1;
    repeat (12) @(negedge clk);
`else
    repeat (20) @(negedge clk);
`endif
    dev_frame[0] = ps2_data_in;
    dev_n = 1;
    for (int e = 1; e <= 11; e++) begin
      if (mode == M_STOP4 && e == 5) break;
      if (e == 11 && mode == M_ACK) dev_data = 1'b0;
      dev_clk = 1'b0;
      if (mode == M_RESET && e == 4) begin
        repeat (10) @(negedge clk);
        chk("busy_before_reset", busy, 1);
        #2 rst_n = 1'b0;
        #1 chk("oe_async_reset", {ps2_clk_oe, ps2_data_oe}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        chk("ready_after_reset", tx_ready, 1);
        chk("pulses_after_reset", {tx_done, tx_error}, 0);
        repeat (60) @(negedge clk);
        return;
      end
      repeat (20) @(negedge clk);
      dev_clk = 1'b1;
      repeat (10) @(negedge clk);
      if (e <= 10) begin
        dev_frame[e] = ps2_data_in;
        dev_n++;
      end
      if (mode == M_NOACK && e == 2) begin
        tx_data  = ~tx_data;
        tx_valid = 1'b1;
        chk("ready_while_busy", tx_ready, 0);
      end
      repeat (10) @(negedge clk);
      tx_valid = 1'b0;
    end
    dev_data = 1'b1;
  endtask

  task automatic run(input logic [7:0] d, input int mode);
    exp_t e;
    int   k;
    logic par;
    par     = ($countones(d) % 2 == 0);
    e.frame = {1'b1, par, d, 1'b0};
    e.mode  = mode;
    e.is_err = (mode != M_ACK);
    e.code  = (mode == M_NOCLK) ? 1 : (mode == M_STOP4) ? 2 : (mode == M_NOACK) ? 3 : 0;
    e.nbits = (mode == M_ACK || mode == M_NOACK) ? 11 : (mode == M_STOP4) ? 5 : 0;
    if (mode != M_RESET) begin
      exp_q.push_back(e);
      if (e.is_err) last_code = e.code;
    end
    @(negedge clk);
    chk("ready_before", tx_ready, 1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("busy_after_accept", busy, 1);
    chk("clk_oe_after_accept", ps2_clk_oe, 1);
    device(mode);
    k = 0;
    while (busy && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("idle_reached", busy, 0);
    repeat (5) @(negedge clk);
    if (mode == M_RESET) last_code = 0;
    chk("err_code_hold", err_code, last_code);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    chk("rst_pulses", {tx_done, tx_error}, 0);
    chk("rst_err_code", err_code, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run(8'hED, M_ACK);
    run(8'hF4, M_ACK);
    run(8'h00, M_ACK);
    run(8'($urandom), M_NOCLK);
    run(8'($urandom), M_STOP4);
    run(8'($urandom), M_NOACK);
    run(8'($urandom), M_ACK);
    run(8'($urandom), M_RESET);
    for (int i = 0; i < 8; i++)
      run(8'($urandom), int'($urandom_range(0, 1)));

    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
